e_muldiv: RTL and testbench

Multi-cycle multiply/divide unit in the E stage of the five-stage MIPS pipeline, beside the ALU and directly upstream of the E/M pipeline register. It executes `mult`, `multu`, `div`, `divu`, `mthi` and `mtlo`, and holds the architectural HI/LO registers. HI/LO feed the E-stage result mux for `mfhi`/`mflo`, and from there the E/M register. Its busy indication drives the hazard unit's stall of D/E for any HI/LO-touching instruction.

---
 rtl/e_muldiv_if.sv | 14 +
 rtl/e_muldiv.sv | 132 +++++++++++++
 tb/tb_e_muldiv.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/e_muldiv_if.sv
// Handshake and result bundle between the E stage and the multiply/divide unit.
interface e_muldiv_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  modport slave  (input start, md_op, a, b, output busy, md_stall, hi, lo);
  modport master (output start, md_op, a, b, input busy, md_stall, hi, lo);
endinterface

// File: rtl/e_muldiv.sv
// Multi-cycle mult/div unit holding architectural HI/LO for the E stage.
// Build option MD_DIV0_KEEP_EN: divide by zero leaves HI/LO untouched.
//
//   state | meaning
//   IDLE  | accepts start; mthi/mtlo write HI/LO directly
//   RUN   | counting down, pending result held in res_hi_q/res_lo_q
module e_muldiv #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic        clk_i,
  input logic        rst_i,
  e_muldiv_if.slave  md
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] res_hi_q, res_lo_q;
  logic [63:0] res_d;

  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div;
  logic [31:0] q_mag, r_mag, quot, rem;

  // Divide works on magnitudes so 0x80000000 / -1 and b==0 never hit signed overflow or X.
  always_comb begin
    prod_s = '0;
    prod_u = '0;
    a_neg  = 1'b0;
    b_neg  = 1'b0;
    a_mag  = md.a;
    b_mag  = md.b;
    b_div  = 32'd1;
    q_mag  = '0;
    r_mag  = '0;
    quot   = '0;
    rem    = '0;
    res_d  = '0;

    prod_s = $signed({{32{md.a[31]}}, md.a}) * $signed({{32{md.b[31]}}, md.b});
    prod_u = {32'd0, md.a} * {32'd0, md.b};

    a_neg = (md.md_op == OP_DIV) && md.a[31];
    b_neg = (md.md_op == OP_DIV) && md.b[31];
    a_mag = a_neg ? -md.a : md.a;
    b_mag = b_neg ? -md.b : md.b;
    b_div = (md.b == 32'd0) ? 32'd1 : b_mag;
    q_mag = a_mag / b_div;
    r_mag = a_mag % b_div;
    quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem   = a_neg ? -r_mag : r_mag;

    case (md.md_op)
      OP_MULT:  res_d = prod_s;
      OP_MULTU: res_d = prod_u;
      OP_DIV, OP_DIVU: begin
        if (md.b == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
          res_d = {hi_q, lo_q};
`else
          res_d = {md.a, 32'hFFFF_FFFF};
`endif
        end else begin
          res_d = {rem, quot};
        end
      end
      default:  res_d = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md.start) begin
            case (md.md_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                res_hi_q <= res_d[63:32];
                res_lo_q <= res_d[31:0];
                cnt_q    <= md.md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                busy_q   <= 1'b1;
                state_q  <= RUN;
              end
              OP_MTHI: hi_q <= md.a;
              OP_MTLO: lo_q <= md.a;
              default: ;
            endcase
          end
        end
        RUN: begin
          // Any start seen here is dropped; the hazard unit keeps D/E stalled.
          if (cnt_q == 4'd1) begin
            hi_q    <= res_hi_q;
            lo_q    <= res_lo_q;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.busy     = busy_q;
  assign md.md_stall = busy_q | (md.start & (md.md_op <= OP_DIVU));
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// Directed bench for e_muldiv with a cycle-level reference model and literal checks.
module tb_e_muldiv;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  e_muldiv_if mif ();

  e_muldiv #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .md    (mif.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic from the instruction definitions, using wide integers.
  function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    if (op >= 3'd2 && b == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
      return cur;
`else
      return {a, 32'hFFFF_FFFF};
`endif
    end
    case (op)
      3'd0: return 64'(sa * sb);
      3'd1: return 64'(ua * ub);
      3'd2: begin
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        q = longint'(ua / ub);
        r = longint'(ua % ub);
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Model: tracks the edge at which the current operation completes.
  int          edge_n = 0;
  int          done_e = 0;
  bit          pend = 0;
  bit          model_ok = 0;
  logic [63:0] pres;
  logic [31:0] m_hi, m_lo;
  logic        m_busy;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_hi = '0;
      m_lo = '0;
      pend = 0;
      done_e = edge_n;
      model_ok = 1;
    end else if (pend && edge_n == done_e) begin
      {m_hi, m_lo} = pres;
      pend = 0;
    end else if (edge_n > done_e && mif.start) begin
      if (mif.md_op <= 3'd3) begin
        pres = md_model(mif.md_op, mif.a, mif.b, {m_hi, m_lo});
        pend = 1;
        done_e = edge_n + ((mif.md_op >= 3'd2) ? DIV_N : MULT_N);
      end else if (mif.md_op == 3'd4) begin
        m_hi = mif.a;
      end else if (mif.md_op == 3'd5) begin
        m_lo = mif.a;
      end
    end
    m_busy = (edge_n < done_e);
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_hi", mif.hi, m_hi);
      chk("model_lo", mif.lo, m_lo);
      chk("model_busy", {31'd0, mif.busy}, {31'd0, m_busy});
      chk("model_stall", {31'd0, mif.md_stall},
          {31'd0, m_busy | (mif.start & (mif.md_op <= 3'd3))});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1;
    mif.md_op = op;
    mif.a = a;
    mif.b = b;
    @(posedge clk);
    #1;
    mif.start = 1'b0;
  endtask

  // Counts busy cycles; returns at the first negedge with busy low.
  task automatic wait_idle(output int cnt);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mif.busy) return;
      cnt++;
    end
    n_vec++;
    n_err++;
    $display("FAIL busy_timeout: busy still high after %0d cycles", cnt);
  endtask

  task automatic op_check(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int c;
    issue(op, a, b);
    wait_idle(c);
    chk({name, "_cycles"}, 32'(c), 32'(exp_cyc));
    chk({name, "_hi"}, mif.hi, exp_hi);
    chk({name, "_lo"}, mif.lo, exp_lo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    mif.start = 1'b0;
    mif.md_op = 3'd7;
    mif.a = '0;
    mif.b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_hi", mif.hi, 32'h0);
    chk("reset_lo", mif.lo, 32'h0);
    chk("reset_busy", {31'd0, mif.busy}, 32'd0);
    chk("reset_stall", {31'd0, mif.md_stall}, 32'd0);
    @(posedge clk);
    #1;

    op_check("mthi", 3'd4, 32'h1234_5678, 32'h0, 0, 32'h1234_5678, 32'h0);
    op_check("mtlo", 3'd5, 32'h9ABC_DEF0, 32'h0, 0, 32'h1234_5678, 32'h9ABC_DEF0);
    op_check("nop6", 3'd6, 32'hDEAD_BEEF, 32'h1, 0, 32'h1234_5678, 32'h9ABC_DEF0);
    op_check("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    op_check("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, MULT_N, 32'h0000_0002, 32'hFFFF_FFFA);
    op_check("div", 3'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_check("divu", 3'd3, 32'd7, 32'd2, DIV_N, 32'd1, 32'd3);
    op_check("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, 32'h0, 32'h8000_0000);
`ifdef MD_DIV0_KEEP_EN
    op_check("divu0", 3'd3, 32'd5, 32'd0, DIV_N, 32'h0, 32'h8000_0000);
`else
    op_check("divu0", 3'd3, 32'd5, 32'd0, DIV_N, 32'd5, 32'hFFFF_FFFF);
`endif
    op_check("div_mix", 3'd2, 32'd100, 32'hFFFF_FFF9, DIV_N, 32'd2, 32'hFFFF_FFF2);

    // mtlo arriving in the third busy cycle must be dropped
    issue(3'd0, 32'h0001_0000, 32'h0003_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    issue(3'd5, 32'hDEAD_BEEF, 32'h0);
    wait_idle(c);
    chk("ign_cycles", 32'(c), 32'd2);
    chk("ign_hi", mif.hi, 32'd3);
    chk("ign_lo", mif.lo, 32'd0);
    @(posedge clk); #1;

    // reset in the third busy cycle, with a simultaneous mthi that reset must override
    issue(3'd0, 32'd9, 32'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    mif.start = 1'b1;
    mif.md_op = 3'd4;
    mif.a = 32'h5555_5555;
    @(posedge clk); #1;
    rst = 1'b0;
    mif.start = 1'b0;
    @(negedge clk);
    chk("rst_abort_hi", mif.hi, 32'h0);
    chk("rst_abort_lo", mif.lo, 32'h0);
    chk("rst_abort_busy", {31'd0, mif.busy}, 32'd0);
    @(posedge clk); #1;

    // back-to-back mults: stall in the start cycle, second accepted as busy falls
    mif.start = 1'b1;
    mif.md_op = 3'd0;
    mif.a = 32'd7;
    mif.b = 32'd6;
    @(negedge clk);
    chk("b2b_stall", {31'd0, mif.md_stall}, 32'd1);
    @(posedge clk); #1;
    mif.start = 1'b0;
    wait_idle(c);
    chk("b2b1_cycles", 32'(c), 32'(MULT_N));
    chk("b2b1_lo", mif.lo, 32'd42);
    #1;
    mif.start = 1'b1;
    mif.a = 32'hFFFF_FFFF;
    mif.b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mif.start = 1'b0;
    wait_idle(c);
    chk("b2b2_cycles", 32'(c), 32'(MULT_N));
    chk("b2b2_hi", mif.hi, 32'h0);
    chk("b2b2_lo", mif.lo, 32'h1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
